exe_stage: RTL

//  EXE pipeline stage of the 5-stage LoongArch core. Latches decoded operands from ID,

---
 rtl/exe_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// EXE stage: latches ID operands, computes the ALU result or runs a radix-2 restoring divider,
// and hands the result to MEM over a valid/allowin handshake.
module exe_stage #(
   parameter int DEST_W = 5,
   parameter bit DIV_EN = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ds_to_es_valid,
   output logic              es_allowin,
   input  logic [11:0]       ds_alu_op,
   input  logic [31:0]       ds_src1,
   input  logic [31:0]       ds_src2,
   input  logic              ds_is_div,
   input  logic              ds_div_signed,
   input  logic              ds_div_mod,
   input  logic [DEST_W-1:0] ds_dest,
   input  logic              ds_rf_we,
   output logic              es_to_ms_valid,
   input  logic              ms_allowin,
   output logic [31:0]       es_result,
   output logic [DEST_W-1:0] es_dest,
   output logic              es_rf_we
);

   typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

   div_state_e        state_q, state_d;
   logic              es_valid_q;
   logic [11:0]       alu_op_q;
   logic [31:0]       src1_q, src2_q;
   logic              is_div_q, div_signed_q, div_mod_q, rf_we_q;
   logic [DEST_W-1:0] dest_q;
   logic [4:0]        count_q;
   logic [31:0]       quo_q, rem_q, dvs_q;

   logic              use_div, es_ready_go;

   assign use_div        = DIV_EN && is_div_q;
   assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid_q && es_ready_go;
   assign es_dest        = dest_q;
   assign es_rf_we       = es_valid_q && rf_we_q;

   // NOTE: every flop is async-reset, divider datapath included, so an aborted divide leaves nothing behind.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_valid_q   <= 1'b0;
         alu_op_q     <= '0;
         src1_q       <= '0;
         src2_q       <= '0;
         is_div_q     <= 1'b0;
         div_signed_q <= 1'b0;
         div_mod_q    <= 1'b0;
         dest_q       <= '0;
         rf_we_q      <= 1'b0;
      end else begin
         if (es_allowin) es_valid_q <= ds_to_es_valid;
         if (ds_to_es_valid && es_allowin) begin
            alu_op_q     <= ds_alu_op;
            src1_q       <= ds_src1;
            src2_q       <= ds_src2;
            is_div_q     <= ds_is_div;
            div_signed_q <= ds_div_signed;
            div_mod_q    <= ds_div_mod;
            dest_q       <= ds_dest;
            rf_we_q      <= ds_rf_we;
         end
      end
   end

   // ALU: one-hot select, bit 0 = add ... bit 11 = lui
   logic [4:0]  shamt;
   logic [31:0] sra_res, alu_res;
   logic        slt_bit, sltu_bit;

   assign shamt    = src2_q[4:0];
   assign sra_res  = $signed(src1_q) >>> shamt;
   assign slt_bit  = $signed(src1_q) < $signed(src2_q);
   assign sltu_bit = src1_q < src2_q;
   assign alu_res  = ({32{alu_op_q[0]}}  & (src1_q + src2_q))
                   | ({32{alu_op_q[1]}}  & (src1_q - src2_q))
                   | ({32{alu_op_q[2]}}  & {31'b0, slt_bit})
                   | ({32{alu_op_q[3]}}  & {31'b0, sltu_bit})
                   | ({32{alu_op_q[4]}}  & (src1_q & src2_q))
                   | ({32{alu_op_q[5]}}  & ~(src1_q | src2_q))
                   | ({32{alu_op_q[6]}}  & (src1_q | src2_q))
                   | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))
                   | ({32{alu_op_q[8]}}  & (src1_q << shamt))
                   | ({32{alu_op_q[9]}}  & (src1_q >> shamt))
                   | ({32{alu_op_q[10]}} & sra_res)
                   | ({32{alu_op_q[11]}} & src2_q);

   // Divider: magnitudes are loaded in IDLE, one restoring step per RUN cycle.
   logic        src1_neg, src2_neg, trial_ok;
   logic [31:0] abs1, abs2, rem_next, q_fix, r_fix, div_res;
   logic [32:0] rem_sh;

   assign src1_neg = div_signed_q && src1_q[31];
   assign src2_neg = div_signed_q && src2_q[31];
   assign abs1     = src1_neg ? -src1_q : src1_q;
   assign abs2     = src2_neg ? -src2_q : src2_q;
   assign rem_sh   = {rem_q, quo_q[31]};
   assign trial_ok = rem_sh >= {1'b0, dvs_q};
   assign rem_next = trial_ok ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
   assign q_fix    = (src1_neg ^ src2_neg) ? -quo_q : quo_q;
   assign r_fix    = src1_neg ? -rem_q : rem_q;
   assign div_res  = (src2_q == 32'd0) ? (div_mod_q ? src1_q : 32'hFFFF_FFFF)
                                       : (div_mod_q ? r_fix : q_fix);

   assign es_result = use_div ? div_res : alu_res;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= DIV_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: defaults first so every path assigns both signals and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      es_ready_go = 1'b1;
      if (use_div) es_ready_go = (state_q == DIV_DONE);
      unique case (state_q)
         DIV_IDLE: if (es_valid_q && use_div)   state_d = DIV_RUN;
         DIV_RUN:  if (count_q == 5'd31)        state_d = DIV_DONE;
         DIV_DONE: if (es_valid_q && ms_allowin) state_d = DIV_IDLE;
         default:                               state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
      end else begin
         unique case (state_q)
            DIV_IDLE: if (es_valid_q && use_div) begin
               quo_q   <= abs1;
               dvs_q   <= abs2;
               rem_q   <= '0;
               count_q <= '0;
            end
            DIV_RUN: begin
               quo_q   <= {quo_q[30:0], trial_ok};
               rem_q   <= rem_next;
               count_q <= count_q + 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
